// File: rtl/ball_motion.sv
// Frame-rate ball position engine with an Avalon-MM register slave.
// Each accepted frame_tick runs IDLE->CALC->BOUNCE->COMMIT and publishes a new ball_x/ball_y.
module ball_motion #(
  parameter int HRES   = 640,
  parameter int VRES   = 480,
  parameter int RADIUS = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  input  logic       frame_tick,
  output logic [9:0] ball_x,
  output logic [9:0] ball_y,
  output logic       update_done,
  output logic       bounce_irq
);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, BOUNCE = 2'd2, COMMIT = 2'd3} state_t;

  localparam logic [9:0]        X_RST = 10'(HRES / 2);
  localparam logic [9:0]        Y_RST = 10'(VRES / 2);
  localparam logic [9:0]        X_LIM = 10'(HRES - 1);
  localparam logic [9:0]        Y_LIM = 10'(VRES - 1);
  localparam logic signed [10:0] P_MIN = 11'(RADIUS);
  localparam logic signed [10:0] X_MAX = 11'(HRES - 1 - RADIUS);
  localparam logic signed [10:0] Y_MAX = 11'(VRES - 1 - RADIUS);

  // Two's-complement negate; -128 has no positive counterpart so it saturates.
  function automatic logic [7:0] neg_sat(input logic [7:0] v);
    if (v == 8'h80) return 8'h7F;
    else            return 8'(~v + 8'd1);
  endfunction

  state_t            state_q, state_d;
  logic [1:0]        ctrl_q, ctrl_d;
  logic [7:0]        vx_q, vx_d, vy_q, vy_d;
  logic [9:0]        sx_q, sx_d, sy_q, sy_d;
  logic [9:0]        x_q, x_d, y_q, y_d;
  logic [10:0]       nx_q, nx_d, ny_q, ny_d;
  logic              load_pass_q, load_pass_d;
  logic              load_pending_q, load_pending_d;
  logic              bx_q, bx_d, by_q, by_d, overrun_q, overrun_d;
  logic              update_done_q, update_done_d;
  logic              bounce_irq_q, bounce_irq_d;
  logic [7:0]        readdata_q, readdata_d;
  logic              wr_s, rd_s;

  assign wr_s = chipselect & write;
  assign rd_s = chipselect & read;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      ctrl_q         <= 2'b00;
      vx_q           <= 8'd1;
      vy_q           <= 8'd1;
      sx_q           <= X_RST;
      sy_q           <= Y_RST;
      x_q            <= X_RST;
      y_q            <= Y_RST;
      nx_q           <= 11'd0;
      ny_q           <= 11'd0;
      load_pass_q    <= 1'b0;
      load_pending_q <= 1'b0;
      bx_q           <= 1'b0;
      by_q           <= 1'b0;
      overrun_q      <= 1'b0;
      update_done_q  <= 1'b0;
      bounce_irq_q   <= 1'b0;
      readdata_q     <= 8'h00;
    end else begin
      state_q        <= state_d;
      ctrl_q         <= ctrl_d;
      vx_q           <= vx_d;
      vy_q           <= vy_d;
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      x_q            <= x_d;
      y_q            <= y_d;
      nx_q           <= nx_d;
      ny_q           <= ny_d;
      load_pass_q    <= load_pass_d;
      load_pending_q <= load_pending_d;
      bx_q           <= bx_d;
      by_q           <= by_d;
      overrun_q      <= overrun_d;
      update_done_q  <= update_done_d;
      bounce_irq_q   <= bounce_irq_d;
      readdata_q     <= readdata_d;
    end
  end

  // Next-state logic: status clear, then FSM, then software writes (last assignment wins).
  always_comb begin
    state_d        = state_q;
    ctrl_d         = ctrl_q;
    vx_d           = vx_q;
    vy_d           = vy_q;
    sx_d           = sx_q;
    sy_d           = sy_q;
    x_d            = x_q;
    y_d            = y_q;
    nx_d           = nx_q;
    ny_d           = ny_q;
    load_pass_d    = load_pass_q;
    load_pending_d = load_pending_q;
    bx_d           = bx_q;
    by_d           = by_q;
    overrun_d      = overrun_q;
    update_done_d  = 1'b0;
    readdata_d     = readdata_q;

    if (wr_s && (address == 3'd7) && writedata[0]) begin
      bx_d      = 1'b0;
      by_d      = 1'b0;
      overrun_d = 1'b0;
    end else begin
      bx_d = bx_q;
    end

    if (frame_tick && (state_q != IDLE)) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_d;
    end

    case (state_q)
      IDLE: begin
        if (frame_tick && (ctrl_q[0] || load_pending_q)) state_d = CALC;
        else                                             state_d = IDLE;
      end
      CALC: begin
        state_d     = BOUNCE;
        load_pass_d = load_pending_q;
        if (load_pending_q) begin
          nx_d           = {1'b0, (sx_q > X_LIM) ? X_LIM : sx_q};
          ny_d           = {1'b0, (sy_q > Y_LIM) ? Y_LIM : sy_q};
          load_pending_d = 1'b0;
        end else begin
          nx_d = {1'b0, x_q} + {{3{vx_q[7]}}, vx_q};
          ny_d = {1'b0, y_q} + {{3{vy_q[7]}}, vy_q};
        end
      end
      BOUNCE: begin
        // Outputs are loaded on this edge so they and update_done appear together in COMMIT.
        state_d       = COMMIT;
        update_done_d = 1'b1;
        x_d           = nx_q[9:0];
        y_d           = ny_q[9:0];
        if (!load_pass_q) begin
          if ($signed(nx_q) < P_MIN) begin
            x_d = P_MIN[9:0]; vx_d = neg_sat(vx_q); bx_d = 1'b1;
          end else if ($signed(nx_q) > X_MAX) begin
            x_d = X_MAX[9:0]; vx_d = neg_sat(vx_q); bx_d = 1'b1;
          end else begin
            x_d = nx_q[9:0];
          end
          if ($signed(ny_q) < P_MIN) begin
            y_d = P_MIN[9:0]; vy_d = neg_sat(vy_q); by_d = 1'b1;
          end else if ($signed(ny_q) > Y_MAX) begin
            y_d = Y_MAX[9:0]; vy_d = neg_sat(vy_q); by_d = 1'b1;
          end else begin
            y_d = ny_q[9:0];
          end
        end else begin
          x_d = nx_q[9:0];
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (wr_s) begin
      case (address)
        3'd0: ctrl_d = writedata[1:0];
        3'd1: vx_d   = writedata;
        3'd2: vy_d   = writedata;
        3'd3: begin sx_d[7:0] = writedata;      load_pending_d = 1'b1; end
        3'd4: begin sx_d[9:8] = writedata[1:0]; load_pending_d = 1'b1; end
        3'd5: begin sy_d[7:0] = writedata;      load_pending_d = 1'b1; end
        3'd6: begin sy_d[9:8] = writedata[1:0]; load_pending_d = 1'b1; end
        default: ctrl_d = ctrl_d;
      endcase
    end else begin
      ctrl_d = ctrl_d;
    end

    if (rd_s) begin
      case (address)
        3'd0:    readdata_d = {6'd0, ctrl_q};
        3'd1:    readdata_d = vx_q;
        3'd2:    readdata_d = vy_q;
        3'd3:    readdata_d = sx_q[7:0];
        3'd4:    readdata_d = {6'd0, sx_q[9:8]};
        3'd5:    readdata_d = sy_q[7:0];
        3'd6:    readdata_d = {6'd0, sy_q[9:8]};
        3'd7:    readdata_d = {3'd0, load_pending_q, overrun_q, (state_q != IDLE), by_q, bx_q};
        default: readdata_d = 8'h00;
      endcase
    end else begin
      readdata_d = readdata_q;
    end

    bounce_irq_d = ctrl_d[1] & (bx_d | by_d);
  end

  assign readdata    = readdata_q;
  assign ball_x      = x_q;
  assign ball_y      = y_q;
  assign update_done = update_done_q;
  assign bounce_irq  = bounce_irq_q;

endmodule

// File: tb/tb_ball_motion.sv
// Directed bench for ball_motion: inputs driven after negedge, outputs sampled at negedge.
module tb_ball_motion;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       chipselect = 1'b0, write = 1'b0, read = 1'b0;
  logic [2:0] address = 3'd0;
  logic [7:0] writedata = 8'h00;
  logic [7:0] readdata;
  logic       frame_tick = 1'b0;
  logic [9:0] ball_x, ball_y;
  logic       update_done, bounce_irq;
  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] rv;

  ball_motion dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write), .read(read),
    .address(address), .writedata(writedata), .readdata(readdata), .frame_tick(frame_tick),
    .ball_x(ball_x), .ball_y(ball_y), .update_done(update_done), .bounce_irq(bounce_irq)
  );

  always #10 clk = ~clk;

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); @(negedge clk); reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk); chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk); chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    @(negedge clk); chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk); chipselect = 1'b0; read = 1'b0; d = readdata;
  endtask

  // Pulse a tick; returns at the negedge of the COMMIT cycle (3 cycles after the tick).
  task automatic tick_and_wait(input string name);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk);
    vectors++;
    if (update_done !== 1'b0) begin
      miscompares++; $display("FAIL %s early_done got %b want 0", name, update_done);
    end
    @(negedge clk);
    vectors++;
    if (update_done !== 1'b1) begin
      miscompares++; $display("FAIL %s done_latency got %b want 1", name, update_done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
      miscompares++; $display("FAIL reset_pos got %0d/%0d want 320/240", ball_x, ball_y);
    end
    vectors++;
    if (update_done !== 1'b0 || bounce_irq !== 1'b0 || readdata !== 8'h00) begin
      miscompares++; $display("FAIL reset_outs got %b %b %h want 0 0 00", update_done, bounce_irq, readdata);
    end
    rd(3'd1, rv); vectors++;
    if (rv !== 8'h01) begin miscompares++; $display("FAIL reset_vx got %h want 01", rv); end
    rd(3'd2, rv); vectors++;
    if (rv !== 8'h01) begin miscompares++; $display("FAIL reset_vy got %h want 01", rv); end
    rd(3'd0, rv); vectors++;
    if (rv !== 8'h00) begin miscompares++; $display("FAIL reset_ctrl got %h want 00", rv); end
    rd(3'd7, rv); vectors++;
    if (rv !== 8'h00) begin miscompares++; $display("FAIL reset_status got %h want 00", rv); end
    rd(3'd3, rv); vectors++;
    if (rv !== 8'h40) begin miscompares++; $display("FAIL reset_xlo got %h want 40", rv); end
    rd(3'd4, rv); vectors++;
    if (rv !== 8'h01) begin miscompares++; $display("FAIL reset_xhi got %h want 01", rv); end
  endtask

  task automatic test_velocity();
    int n;
    do_reset();
    wr(3'd0, 8'h01); wr(3'd1, 8'h03); wr(3'd2, 8'hFE);
    tick_and_wait("velocity");
    vectors++;
    if (ball_x !== 10'd323 || ball_y !== 10'd238) begin
      miscompares++; $display("FAIL velocity_pos got %0d/%0d want 323/238", ball_x, ball_y);
    end
    // Disabled with nothing staged: tick must be ignored.
    wr(3'd0, 8'h00);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin @(negedge clk); if (update_done) n++; end
    vectors++;
    if (n != 0 || ball_x !== 10'd323) begin
      miscompares++; $display("FAIL ignored_tick got %0d pulses x=%0d want 0 pulses x=323", n, ball_x);
    end
  endtask

  task automatic test_bounce_x();
    do_reset();
    wr(3'd3, 8'h6C); wr(3'd4, 8'h02);
    tick_and_wait("load620");
    vectors++;
    if (ball_x !== 10'd620) begin miscompares++; $display("FAIL load620 got %0d want 620", ball_x); end
    wr(3'd0, 8'h03); wr(3'd1, 8'h0A); wr(3'd2, 8'h00);
    tick_and_wait("bounce_x");
    vectors++;
    if (ball_x !== 10'd624 || ball_y !== 10'd240) begin
      miscompares++; $display("FAIL bounce_x_pos got %0d/%0d want 624/240", ball_x, ball_y);
    end
    rd(3'd1, rv); vectors++;
    if (rv !== 8'hF6) begin miscompares++; $display("FAIL bounce_x_vx got %h want f6", rv); end
    rd(3'd7, rv); vectors++;
    if (rv[1:0] !== 2'b01) begin miscompares++; $display("FAIL bounce_x_flags got %b want 01", rv[1:0]); end
    vectors++;
    if (bounce_irq !== 1'b1) begin miscompares++; $display("FAIL irq_set got %b want 1", bounce_irq); end
    wr(3'd0, 8'h02);
    wr(3'd7, 8'h01);
    vectors++;
    if (bounce_irq !== 1'b0) begin miscompares++; $display("FAIL irq_clear got %b want 0", bounce_irq); end
  endtask

  task automatic test_bounce_y_sat();
    do_reset();
    wr(3'd5, 8'd20); wr(3'd6, 8'h00);
    tick_and_wait("load_y20");
    wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd2, 8'h80);
    tick_and_wait("bounce_y");
    vectors++;
    if (ball_y !== 10'd15 || ball_x !== 10'd320) begin
      miscompares++; $display("FAIL bounce_y_pos got %0d/%0d want 320/15", ball_x, ball_y);
    end
    rd(3'd2, rv); vectors++;
    if (rv !== 8'h7F) begin miscompares++; $display("FAIL neg_sat got %h want 7f", rv); end
    rd(3'd7, rv); vectors++;
    if (rv[1:0] !== 2'b10) begin miscompares++; $display("FAIL bounce_y_flags got %b want 10", rv[1:0]); end
  endtask

  task automatic test_staged_load();
    do_reset();
    wr(3'd3, 8'h64); wr(3'd4, 8'h00);
    rd(3'd7, rv); vectors++;
    if (rv[4] !== 1'b1) begin miscompares++; $display("FAIL pending_set got %b want 1", rv[4]); end
    vectors++;
    if (ball_x !== 10'd320) begin miscompares++; $display("FAIL write_no_move got %0d want 320", ball_x); end
    tick_and_wait("load100");
    vectors++;
    if (ball_x !== 10'd100 || ball_y !== 10'd240) begin
      miscompares++; $display("FAIL load100 got %0d/%0d want 100/240", ball_x, ball_y);
    end
    rd(3'd7, rv); vectors++;
    if (rv !== 8'h00) begin miscompares++; $display("FAIL load_status got %h want 00", rv); end
    wr(3'd4, 8'h03); wr(3'd3, 8'hFF);
    tick_and_wait("clamp");
    vectors++;
    if (ball_x !== 10'd639 || ball_y !== 10'd240) begin
      miscompares++; $display("FAIL clamp got %0d/%0d want 639/240", ball_x, ball_y);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    wr(3'd0, 8'h01);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b1;
    n = 0;
    @(negedge clk); frame_tick = 1'b0; if (update_done) n++;
    for (int i = 0; i < 8; i++) begin @(negedge clk); if (update_done) n++; end
    vectors++;
    if (n != 1 || ball_x !== 10'd321 || ball_y !== 10'd241) begin
      miscompares++; $display("FAIL overrun_single got %0d pulses %0d/%0d want 1 321/241", n, ball_x, ball_y);
    end
    rd(3'd7, rv); vectors++;
    if (rv[3] !== 1'b1) begin miscompares++; $display("FAIL tick_overrun got %b want 1", rv[3]); end
    // Software VX write lands on the same edge as the BOUNCE negation.
    wr(3'd3, 8'h6C); wr(3'd4, 8'h02);
    tick_and_wait("load620b");
    wr(3'd1, 8'h0A); wr(3'd2, 8'h00);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); chipselect = 1'b1; write = 1'b1; address = 3'd1; writedata = 8'h05;
    @(negedge clk); chipselect = 1'b0; write = 1'b0;
    vectors++;
    if (update_done !== 1'b1 || ball_x !== 10'd624) begin
      miscompares++; $display("FAIL race_pos got %b/%0d want 1/624", update_done, ball_x);
    end
    rd(3'd1, rv); vectors++;
    if (rv !== 8'h05) begin miscompares++; $display("FAIL sw_wins got %h want 05", rv); end
  endtask

  task automatic test_reset_mid_update();
    int n;
    do_reset();
    wr(3'd0, 8'h01); wr(3'd1, 8'h05);
    @(negedge clk); frame_tick = 1'b1;
    @(negedge clk); frame_tick = 1'b0;
    @(negedge clk); reset = 1'b1;
    #1;
    vectors++;
    if (ball_x !== 10'd320 || ball_y !== 10'd240) begin
      miscompares++; $display("FAIL reset_mid_pos got %0d/%0d want 320/240", ball_x, ball_y);
    end
    n = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (update_done) n++; end
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (update_done) n++; end
    vectors++;
    if (n != 0 || ball_x !== 10'd320) begin
      miscompares++; $display("FAIL reset_mid_done got %0d pulses x=%0d want 0 x=320", n, ball_x);
    end
  endtask

  initial begin
    test_reset();
    test_velocity();
    test_bounce_x();
    test_bounce_y_sat();
    test_staged_load();
    test_back_to_back();
    test_reset_mid_update();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
